// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit_pkg
// Description : Shared CPU definitions: widths, instruction-length bit and
//               fetch-stage state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_unit_pkg;

    localparam int ADDR_W       = 8;
    localparam int DATA_W       = 8;
    localparam int TWO_BYTE_BIT = 7;

    typedef enum logic [1:0] {
        FETCH_OP  = 2'd0,
        FETCH_ARG = 2'd1,
        PRESENT   = 2'd2,
        HALTED    = 2'd3
    } fetch_state_t;

    function automatic logic is_two_byte(input logic [DATA_W-1:0] op);
        return op[TWO_BYTE_BIT];
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction fetch stage; owns the PC, reads 1/2-byte
//               instructions from ROM and hands them to decode (valid/ready).
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 8'h00
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr_op,
    output logic [DATA_W-1:0] instr_arg,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_addr,
    input  logic              halt_req,
    output logic              halted
);

    fetch_state_t      r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [DATA_W-1:0] r_op;
    logic [DATA_W-1:0] r_arg;
    logic [ADDR_W-1:0] r_ipc;

    fetch_state_t      w_next_state;
    logic [ADDR_W-1:0] w_next_pc;
    logic [DATA_W-1:0] w_next_op;
    logic [DATA_W-1:0] w_next_arg;
    logic [ADDR_W-1:0] w_next_ipc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= FETCH_OP;
            r_pc    <= RESET_PC;
            r_op    <= '0;
            r_arg   <= '0;
            r_ipc   <= '0;
        end else begin
            r_state <= w_next_state;
            r_pc    <= w_next_pc;
            r_op    <= w_next_op;
            r_arg   <= w_next_arg;
            r_ipc   <= w_next_ipc;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_pc    = r_pc;
        w_next_op    = r_op;
        w_next_arg   = r_arg;
        w_next_ipc   = r_ipc;

        // Redirect overrides every in-flight step; stale instruction
        // registers are harmless because instr_valid drops with the state.
        if (redirect_valid && (r_state != HALTED)) begin
            w_next_pc    = redirect_addr;
            w_next_state = FETCH_OP;
        end else begin
            unique case (r_state)
                FETCH_OP: begin
                    if (halt_req) begin
                        w_next_state = HALTED;
                    end else begin
                        w_next_op  = rom_data;
                        w_next_ipc = r_pc;
                        w_next_pc  = r_pc + 8'd1;
                        if (is_two_byte(rom_data)) begin
                            w_next_state = FETCH_ARG;
                        end else begin
                            w_next_arg   = '0;
                            w_next_state = PRESENT;
                        end
                    end
                end
                FETCH_ARG: begin
                    w_next_arg   = rom_data;
                    w_next_pc    = r_pc + 8'd1;
                    w_next_state = PRESENT;
                end
                PRESENT: begin
                    if (instr_ready) begin
                        w_next_state = FETCH_OP;
                    end
                end
                HALTED: begin
                    w_next_state = HALTED;
                end
                default: begin
                    w_next_state = FETCH_OP;
                end
            endcase
        end
    end

    assign rom_addr    = r_pc;
    assign instr_op    = r_op;
    assign instr_arg   = r_arg;
    assign instr_pc    = r_ipc;
    assign instr_valid = (r_state == PRESENT);
    assign halted      = (r_state == HALTED);

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the 8-bit CPU. It owns the program counter and drives the program ROM address. It captures one- or two-byte instructions from the ROM's combinational output and presents them to the decoder over a valid/ready handshake. It also accepts jump redirects and a halt request from the execute side.

## Interface
- `RESET_PC`, default 8'h00: PC value loaded on reset.
- `clk`  in  1: system clock; all state updates on rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `rom_addr`  out  8: ROM address, equal to the PC register.
- `rom_data`  in  8: ROM instruction byte, combinational from `rom_addr`.
- `instr_valid`  out  1: `instr_op`, `instr_arg` and `instr_pc` hold a complete instruction.
- `instr_ready`  in  1: decoder accepts the instruction this cycle.
- `instr_op`  out  8: opcode byte.
- `instr_arg`  out  8: operand byte; 8'h00 for one-byte instructions.
- `instr_pc`  out  8: address of the opcode byte.
- `redirect_valid`  in  1: jump request.
- `redirect_addr`  in  8: jump target.
- `halt_req`  in  1: stop fetching.
- `halted`  out  1: fetch stopped; held high until reset.

## Operation
- Instruction length:
  - `op[7]` = 1 means two bytes: opcode followed by operand.
  - `op[7]` = 0 means one byte.
- State machine states: FETCH_OP, FETCH_ARG, PRESENT, HALTED. Reset state is FETCH_OP.
- FETCH_OP:
  - If `halt_req`=1, go to HALTED. The PC is unchanged.
  - Otherwise latch `instr_op` ← `rom_data`, `instr_pc` ← PC, and PC ← PC+1.
  - If `rom_data[7]`=1, go to FETCH_ARG.
  - Otherwise set `instr_arg` ← 0 and go to PRESENT.
- FETCH_ARG: latch `instr_arg` ← `rom_data`, PC ← PC+1, go to PRESENT.
- PRESENT:
  - `instr_valid`=1.
  - Outputs are stable until `instr_ready`=1.
  - On handshake, go to FETCH_OP.
- HALTED:
  - `halted`=1 and `instr_valid`=0.
  - PC is frozen; `redirect_valid` and `halt_req` are ignored.
  - Only `rst` exits this state.
- Redirect, when not in HALTED:
  - `redirect_valid`=1 has priority over all other transitions: PC ← `redirect_addr`, state ← FETCH_OP.
  - A partially fetched instruction is discarded.
  - If redirect and handshake coincide in PRESENT, the handshake counts as accepted and the redirect still applies.
  - If redirect and `halt_req` coincide, the redirect wins. Halt is evaluated again in the next FETCH_OP.
- `halt_req` is sampled only in FETCH_OP. A fetch already in progress completes and is presented first.
- PC arithmetic is 8-bit modulo: 8'hFF+1 = 8'h00. A two-byte opcode at 8'hFF takes its operand from 8'h00.

## Timing
- Reset values:
  - `rom_addr` = `RESET_PC`.
  - `instr_valid` = 0, `halted` = 0.
  - `instr_op`, `instr_arg` and `instr_pc` = 8'h00.
- `rst` has priority over everything, including mid-fetch and HALTED. It takes effect at the next edge.
- `rom_addr` is a registered output. `rom_data` must settle within the same cycle.
- Latency:
  - One-byte instruction: `instr_valid` rises 1 cycle after entering FETCH_OP.
  - Two-byte instruction: `instr_valid` rises 2 cycles after entering FETCH_OP.
- Throughput with `instr_ready` held high:
  - One instruction every 2 cycles for one-byte instructions.
  - One instruction every 3 cycles for two-byte instructions.
- A redirect asserted in cycle N puts `redirect_addr` on `rom_addr` in cycle N+1. `instr_valid` is 0 in cycle N+1.
- `instr_valid` never drops without a handshake, except on redirect or reset.

## Structure
- Shared CPU package holds:
  - The state enum.
  - `TWO_BYTE_BIT` = 7.
  - Address and data width constants (8).
- No sub-module. The PC register, state machine and output registers sit in one module.
- The top level connects `rom_addr`/`rom_data` directly to the program ROM.

## Test plan
- One-byte stream: ROM 00:8'h01, 01:8'h02, ready=1 → `instr_op` 01 then 02, with `instr_pc` 00 and 01, `instr_arg` 00, `instr_valid` pulses 2 cycles apart.
- Two-byte instruction: ROM 00:8'h85, 01:8'h3C → one instruction with op 85, arg 3C, pc 00. The next fetch is at 02.
- Backpressure: ready=0 for 5 cycles during PRESENT → outputs and `rom_addr` are frozen. The handshake on the ready=1 cycle advances the stage to FETCH_OP.
- Redirect: redirect_valid=1 with addr 8'h40 during FETCH_ARG → the partial instruction is dropped, `rom_addr`=40 next cycle, and the next presented `instr_pc`=40.
- Wrap: redirect to 8'hFF with ROM FF:8'h90, 00:8'h11 → op 90, arg 11, pc FF. The following `rom_addr` is 01.
- Halt and reset: `halt_req`=1 in FETCH_OP → `halted`=1 next cycle, and a later redirect is ignored. Asserting `rst` → `halted`=0, `rom_addr`=`RESET_PC`.
